// File: rtl/mc_datapath_regs.sv
// State-register bank of the multicycle datapath: PC, OldPC, IR, MDR, A, B, ALUOut, plus memory-wait stall.
// Optional retired-instruction counter is enabled by defining MC_INSTRET_CNT_EN.
module mc_datapath_regs #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pcwrite,
   input  logic            IRWrite,
   input  logic            AddrSrc,
   input  logic [1:0]      ResultSrc,
   input  logic            mem_rd,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] old_pc,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] a_reg,
   output logic [XLEN-1:0] b_reg,
   output logic [XLEN-1:0] alu_out,
   output logic            stall
`ifdef MC_INSTRET_CNT_EN
   ,output logic [63:0]    instret
`endif
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] old_pc_q, old_pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] mdr_q, mdr_d;
   logic [XLEN-1:0] a_q, b_q, alu_out_q;
   logic            fetch_go;

   // Stall is forced low while reset is held so the control FSM sees a clean FETCH.
   assign stall    = ~reset & (IRWrite | mem_rd) & ~mem_ready;
   assign fetch_go = IRWrite & ~stall;

   always_comb begin
      result = alu_out_q;
      case (ResultSrc)
         2'b01:   result = mdr_q;
         2'b10:   result = alu_result;
         default: result = alu_out_q;
      endcase
   end

   assign mem_addr  = AddrSrc ? result : pc_q;
   assign mem_wdata = b_q;
   assign pc        = pc_q;
   assign old_pc    = old_pc_q;
   assign instr     = instr_q;
   assign a_reg     = a_q;
   assign b_reg     = b_q;
   assign alu_out   = alu_out_q;

   always_comb begin
      pc_d     = pc_q;
      old_pc_d = old_pc_q;
      instr_d  = instr_q;
      mdr_d    = mdr_q;
      if (pcwrite && !stall)
         pc_d = result;
      // OldPC samples the pre-update PC, even when PC loads in the same cycle.
      if (fetch_go) begin
         instr_d  = mem_rdata[31:0];
         old_pc_d = pc_q;
      end
      if (mem_rd && mem_ready)
         mdr_d = mem_rdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= XLEN'(RESET_PC);
         old_pc_q  <= '0;
         instr_q   <= '0;
         mdr_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
      end else begin
         pc_q      <= pc_d;
         old_pc_q  <= old_pc_d;
         instr_q   <= instr_d;
         mdr_q     <= mdr_d;
         a_q       <= rd1;
         b_q       <= rd2;
         alu_out_q <= alu_result;
      end
   end

`ifdef MC_INSTRET_CNT_EN
   logic [63:0] instret_q, instret_d;

   assign instret_d = fetch_go ? instret_q + 64'd1 : instret_q;
   assign instret   = instret_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) instret_q <= '0;
      else       instret_q <= instret_d;
   end
`endif

endmodule

// File: doc/mc_datapath_regs.md
Name: mc_datapath_regs

Overview:
State-register bank of the multicycle datapath, directly downstream of the control unit. It consumes pcwrite, IRWrite, AddrSrc and ResultSrc, and holds PC, OldPC, IR, MDR, A, B and ALUOut. It drives the unified memory address and the Result bus, and feeds the fetched instruction back to the control unit. It also adds a memory-wait handshake that stalls the control FSM.

Parameters:
XLEN, 32, datapath width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, all registers update on rising edge.
reset  input  1  asynchronous, active-high reset.
pcwrite  input  1  PC load enable from the control unit.
IRWrite  input  1  load IR and OldPC from the fetch.
AddrSrc  input  1  memory address select: 0 = PC, 1 = Result.
ResultSrc  input  2  Result select: 00 = ALUOut, 01 = MDR, 10 = alu_result, 11 = ALUOut.
mem_rd  input  1  control FSM is in a data-memory read cycle.
mem_ready  input  1  memory read data valid this cycle.
alu_result  input  XLEN  combinational ALU output.
rd1  input  XLEN  register-file read port 1.
rd2  input  XLEN  register-file read port 2.
mem_rdata  input  XLEN  memory read data.
mem_addr  output  XLEN  unified memory address.
mem_wdata  output  XLEN  store data, equal to B.
result  output  XLEN  Result bus: PC next value and register-file write data.
pc  output  XLEN  current PC.
old_pc  output  XLEN  PC of the instruction held in IR.
instr  output  32  instruction register, goes to the control unit.
a_reg  output  XLEN  registered rd1.
b_reg  output  XLEN  registered rd2.
alu_out  output  XLEN  registered alu_result.
stall  output  1  hold the control FSM in its current state.

Behaviour:
- Reset (asynchronous, any cycle, including mid-stall):
  - pc = RESET_PC.
  - old_pc, instr, mdr, a_reg, b_reg, alu_out = 0.
  - stall = 0 after reset; it is combinational, so it follows inputs once reset is released.
  - instr = 0 decodes as a non-branch, non-write opcode; the control unit must be in FETCH after reset.
- stall = (IRWrite | mem_rd) & ~mem_ready. This path is combinational, so there is zero added latency when memory is ready.
- PC: pc <= result when pcwrite & ~stall. Otherwise it holds.
  - pcwrite asserted during a stall is dropped. The control unit re-asserts it on the retried cycle.
- IR and OldPC: when IRWrite & ~stall, instr <= mem_rdata and old_pc <= pc (the pre-update value).
  - If IRWrite and pcwrite both take effect in the same cycle, OldPC captures the old PC and PC takes result.
- MDR: mdr <= mem_rdata when mem_rd & mem_ready. Otherwise it holds.
- A, B and ALUOut load unconditionally every cycle, one cycle after their inputs, with no enable. During a stall they still load, because the control FSM holds its operands stable.
- result mux is combinational from ALUOut, mdr and alu_result. ResultSrc = 11 selects ALUOut.
- mem_addr = AddrSrc ? result : pc, combinational.
- mem_wdata = b_reg.
- Arithmetic: no arithmetic is done here. PC+4 and branch targets come from the ALU via result, and all widths pass through unchanged.
- Stall of any length is legal: registers gated by ~stall hold indefinitely.
- mem_ready high when neither IRWrite nor mem_rd is asserted is ignored.

Optional Feature:
Macro: MC_INSTRET_CNT_EN.
- Defined:
  - Adds output instret, 64 bits, reset to 0.
  - instret increments by 1 on every cycle with IRWrite & ~stall.
  - Wraps from 2^64-1 to 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
1. Reset: hold reset with RESET_PC = 32'h0000_1000 -> pc = 32'h1000, instr = 0, stall = 0. Assert reset mid-stall -> all registers return to reset values immediately, without waiting for a clock edge.
2. Fetch: mem_rdata = 32'h00500093, IRWrite = 1, pcwrite = 1, ResultSrc = 10, alu_result = 32'h1004, mem_ready = 1 -> next cycle instr = 32'h00500093, old_pc = 32'h1000, pc = 32'h1004.
3. Fetch stall: same as test 2 but mem_ready = 0 for 3 cycles -> stall = 1, pc, instr and old_pc unchanged. On the 4th cycle mem_ready = 1 -> values load as in test 2.
4. Load path: AddrSrc = 1, ResultSrc = 00, alu_out = 32'h2000 -> mem_addr = 32'h2000. With mem_rd = 1, mem_ready = 1 and mem_rdata = 32'hDEADBEEF, then ResultSrc = 01 -> result = 32'hDEADBEEF.
5. Branch-not-taken: pcwrite = 0, ResultSrc = 00 -> pc holds and alu_out updates each cycle. Check ResultSrc = 11 returns alu_out.
6. With MC_INSTRET_CNT_EN: 5 fetches, one of them stalled 2 cycles -> instret = 5. Preload the counter to 64'hFFFF_FFFF_FFFF_FFFF, do 1 fetch -> instret = 0.
